regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU), and tracks registers with an MDU result still in flight. Decode uses its stall output to avoid reading, or re-targeting, such a register before the result lands. It sits between WB/MDU and the register file, driving the register file's `writeRpoint`/`writeData`/`writeEnable`.

## Interface
Parameters:
- `DEPTH`, 2: MDU result buffer entries (≥1).
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `wbEnable`  in  1  pipeline WB write request; cannot be stalled.
- `wbRpoint`  in  ADDR_W  WB destination.
- `wbData`  in  DATA_W  WB data.
- `mduValid`  in  1  MDU result offered.
- `mduReady`  out  1  buffer can accept; a transfer happens when `mduValid && mduReady` at posedge.
- `mduRpoint`  in  ADDR_W  MDU destination.
- `mduData`  in  DATA_W  MDU result.
- `issueValid`  in  1  decode presents an instruction.
- `issueIsMdu`  in  1  instruction is an MDU op.
- `R1point`, `R2point`  in  ADDR_W  decode source registers.
- `destRpoint`  in  ADDR_W  decode destination.
- `hazardStall`  out  1  decode must hold.
- `writeRpoint`  out  ADDR_W  to register file.
- `writeData`  out  DATA_W  to register file.
- `writeEnable`  out  1  to register file.
- `pendingMask`  out  32  per-register in-flight MDU flag, for debug.

## Operation
- Write-port mux (combinational):
  - If `wbEnable && wbRpoint!=0`, grant WB and pass `wbRpoint`/`wbData`.
  - Otherwise, if the buffer is non-empty, grant the buffer head. Its entry pops at posedge.
  - Otherwise `writeEnable=0`.
- A WB write to r0 never asserts `writeEnable`. It also does not block a buffer drain that cycle.
- MDU buffer: FIFO of {rpoint, data}, `DEPTH` entries.
  - `mduReady = !full && !rst`.
  - A push while full is impossible, even if a pop occurs the same cycle.
  - Simultaneous push and pop when non-full keeps the count unchanged.
- An MDU entry with rpoint 0 is accepted and, on reaching the head, popped without a write, regardless of `wbEnable`.
- Pending bits `pending[31:0]`:
  - Bit 0 is hard-wired 0.
  - Set at posedge when `issueValid && issueIsMdu && !hazardStall && destRpoint!=0`.
  - Cleared at posedge when the buffer head for that register is granted.
  - If set and clear hit the same register in the same cycle, set wins.
- `hazardStall = issueValid && (pending[R1point] | pending[R2point] | pending[destRpoint])`. This covers RAW and WAW against in-flight MDU results. Upstream holds all issue inputs while stalled.
- Reset (`rst` high at posedge):
  - Buffer becomes empty and all pending bits clear. In-flight MDU data is discarded.
  - While `rst` is high: `mduReady=0`, `writeEnable=0`, `hazardStall=0`.
  - `writeRpoint`/`writeData` are 0 after reset with no request.

## Timing
- WB path: zero latency. Same-cycle passthrough preserves the existing negedge register-file write.
- MDU path: at least 1 cycle from accept to `writeEnable`, since the entry must first be buffered. Each cycle of continuous WB traffic adds one cycle.
- Pending clears at the posedge ending the granted write cycle. The register file writes at that cycle's negedge, so decode reads correct data in the first unstalled cycle.
- Buffer starvation under continuous WB is permitted. The buffer fills, `mduReady` drops, and the MDU holds.
- Reset is honoured mid-transfer on the next posedge. No partial state is retained.

## Structure
- Shared package `regfile_pkg`: `ADDR_W`, `DATA_W`, the `wb_entry_t` struct {rpoint, data}, and the constant `ZERO_REG = 0`.
- One sub-module, `regfile_wb_fifo`: a parameterised synchronous FIFO of `wb_entry_t` with push/pop/full/empty.
- Mux, pending array and stall logic live in the top level.

## Test plan
- WB only:
  - Stimulus: `wbEnable=1`, `wbRpoint=5`, `wbData=0xDEAD` for one cycle, then `wbRpoint=0`.
  - Response: `writeEnable=1`, `writeRpoint=5` same cycle. The r0 cycle gives `writeEnable=0`.
- MDU drain:
  - Stimulus: issue MDU op, dest 8. Push `mduRpoint=8`, `mduData=0x1234` with WB idle.
  - Response: write r8 the next cycle. `pending[8]` clears at the following posedge, and `hazardStall` drops for a reader of r8.
- Conflict:
  - Stimulus: WB to r3 for 4 consecutive cycles while MDU pushes r9 then r10 (`DEPTH=2`).
  - Response: WB wins every cycle and `mduReady=0` after the second push. r9 is written first, then r10, once WB goes idle.
- Hazards:
  - Stimulus: r12 pending; issue with `R2point=12`, then with `destRpoint=12`.
  - Response: `hazardStall=1` for both. An MDU issue with dest 12 does not re-set the bit until the stall clears.
- Same-cycle set and clear:
  - Stimulus: buffer head r7 granted while a new MDU op with dest 7 issues (no stall).
  - Response: `pending[7]` remains 1.
- Reset mid-operation:
  - Stimulus: buffer holding 2 entries, pending {4, 6}. Assert `rst` for one cycle.
  - Response: no writes, `pendingMask=0`, buffer empty, `mduReady=1` on the cycle after `rst` falls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter and its MDU result buffer.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rpoint;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Synchronous FIFO of pending MDU writebacks; pushes when full and pops when empty are ignored.
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (always first) and buffered MDU results,
// and stalls decode against registers whose MDU result has not yet been written.
module regfile_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbEnable,
    input  logic [ADDR_W-1:0] wbRpoint,
    input  logic [DATA_W-1:0] wbData,
    input  logic              mduValid,
    output logic              mduReady,
    input  logic [ADDR_W-1:0] mduRpoint,
    input  logic [DATA_W-1:0] mduData,
    input  logic              issueValid,
    input  logic              issueIsMdu,
    input  logic [ADDR_W-1:0] R1point,
    input  logic [ADDR_W-1:0] R2point,
    input  logic [ADDR_W-1:0] destRpoint,
    output logic              hazardStall,
    output logic [ADDR_W-1:0] writeRpoint,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic [31:0]       pendingMask
);

    import regfile_pkg::*;

    wb_entry_t   push_entry, head;
    logic        full, empty;
    logic        mdu_push, wb_grant, head_is_r0, buf_pop, buf_write, pend_set;
    logic [31:0] pending_q, pending_d;

    assign push_entry = '{rpoint: mduRpoint, data: mduData};
    assign mduReady   = !full && !rst;
    assign mdu_push   = mduValid && mduReady;

    assign wb_grant   = wbEnable && (wbRpoint != ZERO_REG);
    assign head_is_r0 = (head.rpoint == ZERO_REG);
    // An r0 head drains even under WB traffic since it needs no write port.
    assign buf_pop    = !empty && !rst && (!wb_grant || head_is_r0);
    assign buf_write  = buf_pop && !head_is_r0;

    regfile_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (mdu_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        writeEnable = 1'b0;
        writeRpoint = '0;
        writeData   = '0;
        if (!rst) begin
            if (wb_grant) begin
                writeEnable = 1'b1;
                writeRpoint = wbRpoint;
                writeData   = wbData;
            end else if (buf_write) begin
                writeEnable = 1'b1;
                writeRpoint = head.rpoint;
                writeData   = head.data;
            end
        end
    end

    assign hazardStall = issueValid && !rst &&
                         (pending_q[R1point] | pending_q[R2point] | pending_q[destRpoint]);
    assign pend_set    = issueValid && issueIsMdu && !hazardStall && (destRpoint != ZERO_REG);

    // Set is applied after clear so a same-cycle re-issue to the draining register wins.
    always_comb begin
        pending_d = pending_q;
        if (buf_pop)  pending_d[head.rpoint] = 1'b0;
        if (pend_set) pending_d[destRpoint]  = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign pendingMask = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change at negedge, outputs sampled 1ns later.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEnable;
    logic [4:0]  wbRpoint;
    logic [31:0] wbData;
    logic        mduValid;
    logic        mduReady;
    logic [4:0]  mduRpoint;
    logic [31:0] mduData;
    logic        issueValid;
    logic        issueIsMdu;
    logic [4:0]  R1point;
    logic [4:0]  R2point;
    logic [4:0]  destRpoint;
    logic        hazardStall;
    logic [4:0]  writeRpoint;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] pendingMask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wbEnable    (wbEnable),
        .wbRpoint    (wbRpoint),
        .wbData      (wbData),
        .mduValid    (mduValid),
        .mduReady    (mduReady),
        .mduRpoint   (mduRpoint),
        .mduData     (mduData),
        .issueValid  (issueValid),
        .issueIsMdu  (issueIsMdu),
        .R1point     (R1point),
        .R2point     (R2point),
        .destRpoint  (destRpoint),
        .hazardStall (hazardStall),
        .writeRpoint (writeRpoint),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .pendingMask (pendingMask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wbEnable   = 1'b0; wbRpoint  = '0; wbData  = '0;
        mduValid   = 1'b0; mduRpoint = '0; mduData = '0;
        issueValid = 1'b0; issueIsMdu = 1'b0;
        R1point    = '0;   R2point   = '0; destRpoint = '0;
    endtask

    // Advance to the next negedge with all inputs idle.
    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // reset state
        @(negedge clk);
        issueValid = 1'b1; R1point = 5'd4;
        settle();
        check("rst_ready", mduReady, 0);
        check("rst_we", writeEnable, 0);
        check("rst_stall", hazardStall, 0);
        next_cycle(); rst = 1'b0; settle();
        check("post_rst_ready", mduReady, 1);
        check("post_rst_we", writeEnable, 0);
        check("post_rst_rp", writeRpoint, 0);
        check("post_rst_wd", writeData, 0);
        check("post_rst_pend", pendingMask, 0);

        // WB passthrough, then r0 suppressed
        next_cycle(); wbEnable = 1; wbRpoint = 5; wbData = 32'hDEAD; settle();
        check("wb_we", writeEnable, 1);
        check("wb_rp", writeRpoint, 5);
        check("wb_wd", writeData, 32'hDEAD);
        next_cycle(); wbEnable = 1; wbRpoint = 0; wbData = 32'hBEEF; settle();
        check("wb_r0_we", writeEnable, 0);

        // MDU drain into r8
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 8; settle();
        check("mdu_issue_stall", hazardStall, 0);
        next_cycle(); mduValid = 1; mduRpoint = 8; mduData = 32'h1234; settle();
        check("mdu_pend8", pendingMask, 32'h0000_0100);
        check("mdu_ready", mduReady, 1);
        check("mdu_push_we", writeEnable, 0);
        next_cycle(); issueValid = 1; R1point = 8; destRpoint = 2; settle();
        check("mdu_drain_we", writeEnable, 1);
        check("mdu_drain_rp", writeRpoint, 8);
        check("mdu_drain_wd", writeData, 32'h1234);
        check("mdu_raw_stall", hazardStall, 1);
        next_cycle(); issueValid = 1; R1point = 8; destRpoint = 2; settle();
        check("mdu_pend_clr", pendingMask, 0);
        check("mdu_stall_drop", hazardStall, 0);
        check("mdu_idle_we", writeEnable, 0);

        // WB conflict, buffer fills, then drains in order
        next_cycle(); wbEnable = 1; wbRpoint = 3; wbData = 32'hA0;
        mduValid = 1; mduRpoint = 9; mduData = 32'h99; settle();
        check("cf0_rp", writeRpoint, 3);
        check("cf0_ready", mduReady, 1);
        next_cycle(); wbEnable = 1; wbRpoint = 3; wbData = 32'hA1;
        mduValid = 1; mduRpoint = 10; mduData = 32'h1010; settle();
        check("cf1_rp", writeRpoint, 3);
        check("cf1_ready", mduReady, 1);
        next_cycle(); wbEnable = 1; wbRpoint = 3; wbData = 32'hA2; settle();
        check("cf2_wd", writeData, 32'hA2);
        check("cf2_ready", mduReady, 0);
        next_cycle(); wbEnable = 1; wbRpoint = 3; wbData = 32'hA3; settle();
        check("cf3_rp", writeRpoint, 3);
        check("cf3_ready", mduReady, 0);
        next_cycle(); wbEnable = 1; wbRpoint = 0; wbData = 32'hFFFF; settle();
        check("cf4_we", writeEnable, 1);
        check("cf4_rp", writeRpoint, 9);
        check("cf4_wd", writeData, 32'h99);
        next_cycle(); settle();
        check("cf5_rp", writeRpoint, 10);
        check("cf5_wd", writeData, 32'h1010);
        check("cf5_ready", mduReady, 1);
        next_cycle(); settle();
        check("cf6_we", writeEnable, 0);

        // hazards against r12
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 12; settle();
        check("hz_issue_stall", hazardStall, 0);
        next_cycle(); issueValid = 1; R2point = 12; destRpoint = 1; settle();
        check("hz_raw_r2", hazardStall, 1);
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 12; settle();
        check("hz_waw", hazardStall, 1);
        next_cycle(); issueValid = 1; issueIsMdu = 1; R1point = 12; destRpoint = 11; settle();
        check("hz_stalled_mdu", hazardStall, 1);
        next_cycle(); issueValid = 0; R1point = 12; settle();
        check("hz_no_issue", hazardStall, 0);
        check("hz_no_reset", pendingMask, 32'h0000_1000);
        next_cycle(); mduValid = 1; mduRpoint = 12; mduData = 32'hC; settle();
        next_cycle(); settle();
        check("hz_drain_rp", writeRpoint, 12);
        next_cycle(); settle();
        check("hz_clear", pendingMask, 0);

        // same-cycle set and clear on r7
        next_cycle(); mduValid = 1; mduRpoint = 7; mduData = 32'h77; settle();
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 7; settle();
        check("sc_stall", hazardStall, 0);
        check("sc_rp", writeRpoint, 7);
        next_cycle(); settle();
        check("sc_set_wins", pendingMask, 32'h0000_0080);

        // reset with buffer full and pending {4,6,7}
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 4;
        next_cycle(); issueValid = 1; issueIsMdu = 1; destRpoint = 6;
        next_cycle(); wbEnable = 1; wbRpoint = 3; mduValid = 1; mduRpoint = 4; mduData = 32'h44;
        next_cycle(); wbEnable = 1; wbRpoint = 3; mduValid = 1; mduRpoint = 6; mduData = 32'h66;
        next_cycle(); settle();
        check("rm_pend", pendingMask, 32'h0000_00D0);
        check("rm_full", mduReady, 0);
        rst = 1; issueValid = 1; R1point = 4; settle();
        check("rm_rst_we", writeEnable, 0);
        check("rm_rst_stall", hazardStall, 0);
        next_cycle(); rst = 0; settle();
        check("rm_after_we", writeEnable, 0);
        check("rm_after_pend", pendingMask, 0);
        check("rm_after_ready", mduReady, 1);
        next_cycle(); settle();
        check("rm_empty_we", writeEnable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
